draw_tile_grid: RTL and testbench

Parametrised tile-grid image drawer for the VGA pipeline: overlays a COLS×ROWS grid of equally sized bitmap tiles on the incoming vga_if stream, fetching pixels from an external image ROM. It adds four things: ROM-latency compensation, tile-indexed ROM addressing instead of one RGB input per image, a frame-synchronous selection register, and a blinking highlight border on the selected tile. It sits between the background/sprite stages and the next vga_if consumer.

---
 rtl/draw_tile_grid_if.sv | 16 +
 rtl/draw_tile_grid.sv | 185 ++++++++++++++++++
 tb/tb_draw_tile_grid.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_tile_grid_if.sv
// VGA pixel stream bundle passed between drawing stages: timing counters,
// sync/blanking flags and the 12-bit colour of the current pixel.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_tile_grid.sv
// Overlays a COLS x ROWS grid of ROM tiles on the VGA stream, hiding the ROM
// latency and drawing a blinking border around the frame-synchronously selected tile.
module draw_tile_grid #(
    parameter int          COLS         = 3,
    parameter int          ROWS         = 2,
    parameter int          TILE_W       = 156,
    parameter int          TILE_H       = 200,
    parameter int          X0           = 50,
    parameter int          Y0           = 50,
    parameter int          X_PITCH      = 200,
    parameter int          Y_PITCH      = 220,
    parameter int          ROM_LAT      = 1,
    parameter int          BORDER       = 3,
    parameter logic [11:0] HL_COLOR     = 12'hFF0,
    parameter int          BLINK_FRAMES = 30,
    localparam int         ADDR_W       = $clog2(TILE_W*TILE_H),
    localparam int         TIDX_W       = (COLS*ROWS > 1) ? $clog2(COLS*ROWS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    vga_if.in                 in,
    vga_if.out                out,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [TIDX_W-1:0] rom_tile,
    input  logic [11:0]       rom_rgb,
    input  logic [TIDX_W-1:0] sel_tile,
    input  logic              sel_valid,
    input  logic              hl_en
);
    localparam int NT    = COLS*ROWS;
    localparam int DEPTH = 1 + ROM_LAT;
    localparam int SEL_W = TIDX_W + 1;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef struct packed {
        logic [10:0]       hcount;
        logic [10:0]       vcount;
        logic              hsync;
        logic              vsync;
        logic              hblnk;
        logic              vblnk;
        logic [11:0]       rgb;
        logic              hit;
        logic [TIDX_W-1:0] tile;
        logic              border;
        logic              hl;
    } stage_t;

    int                hc, vc, col, row, lx, ly;
    logic              col_hit, row_hit;
    stage_t            s0;
    logic [ADDR_W-1:0] addr0;
    stage_t            pipe [DEPTH];
    stage_t            tail;

    logic              vs_q, vs_rise;
    logic [SEL_W-1:0]  pending, active;
    logic              active_ok;
    logic [FC_W-1:0]   frame_cnt;
    logic              blink_on;
    logic              highlight;
    logic [11:0]       rgb_nxt;

    // Columns and rows are scanned from the highest index down so that the
    // lowest-index tile wins where tiles overlap.
    always_comb begin
        hc      = int'(in.hcount);
        vc      = int'(in.vcount);
        col_hit = 1'b0;
        row_hit = 1'b0;
        col     = 0;
        row     = 0;
        lx      = 0;
        ly      = 0;
        for (int c = COLS-1; c >= 0; c--) begin
            if (hc >= X0 + c*X_PITCH && hc < X0 + c*X_PITCH + TILE_W) begin
                col_hit = 1'b1;
                col     = c;
                lx      = hc - X0 - c*X_PITCH;
            end
        end
        for (int r = ROWS-1; r >= 0; r--) begin
            if (vc >= Y0 + r*Y_PITCH && vc < Y0 + r*Y_PITCH + TILE_H) begin
                row_hit = 1'b1;
                row     = r;
                ly      = vc - Y0 - r*Y_PITCH;
            end
        end
        s0        = '0;
        s0.hcount = in.hcount;
        s0.vcount = in.vcount;
        s0.hsync  = in.hsync;
        s0.vsync  = in.vsync;
        s0.hblnk  = in.hblnk;
        s0.vblnk  = in.vblnk;
        s0.rgb    = in.rgb;
        s0.hit    = col_hit && row_hit;
        s0.tile   = TIDX_W'(row*COLS + col);
        s0.border = (lx < BORDER) || (lx >= TILE_W - BORDER) ||
                    (ly < BORDER) || (ly >= TILE_H - BORDER);
        s0.hl     = hl_en;
        addr0     = ADDR_W'(ly*TILE_W + lx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
            rom_tile <= '0;
        end else if (s0.hit) begin
            rom_addr <= addr0;
            rom_tile <= s0.tile;
        end
    end

    // The tail of this delay line lines up with rom_rgb for the same pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= s0;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tail    = pipe[DEPTH-1];
    assign vs_rise = in.vsync && !vs_q;

    // Selection is one bit wider than a tile index so all-ones never names a real tile.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q    <= 1'b0;
            pending <= '1;
            active  <= '1;
        end else begin
            vs_q <= in.vsync;
            if (sel_valid) pending <= {1'b0, sel_tile};
            if (vs_rise)   active  <= sel_valid ? {1'b0, sel_tile} : pending;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (vs_rise) begin
            if (BLINK_FRAMES != 0 && frame_cnt == FC_W'(BLINK_FRAMES-1)) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign active_ok = active < SEL_W'(NT);

    always_comb begin
        highlight = tail.hit && active_ok && (tail.tile == active[TIDX_W-1:0]) &&
                    tail.border && tail.hl && blink_on;
        rgb_nxt   = tail.rgb;
        if (tail.hblnk || tail.vblnk) rgb_nxt = 12'h000;
        else if (highlight)           rgb_nxt = HL_COLOR;
        else if (tail.hit)            rgb_nxt = rom_rgb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out.hcount <= '0;
            out.vcount <= '0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.hcount <= tail.hcount;
            out.vcount <= tail.vcount;
            out.hsync  <= tail.hsync;
            out.vsync  <= tail.vsync;
            out.hblnk  <= tail.hblnk;
            out.vblnk  <= tail.vblnk;
            out.rgb    <= rgb_nxt;
        end
    end
endmodule

// File: tb/tb_draw_tile_grid.sv
// Scoreboard bench for draw_tile_grid: a ROM_LAT=1/BLINK_FRAMES=2 instance and a
// ROM_LAT=2 instance share the input stream; expectations are queued with due cycles.
module tb_draw_tile_grid;
    logic        clk;
    logic        rst;
    logic [2:0]  sel_tile;
    logic        sel_valid;
    logic        hl_en;
    logic [14:0] rom_addr_a, rom_addr_b;
    logic [2:0]  rom_tile_a, rom_tile_b;
    logic [11:0] rom_rgb_a, rom_b1, rom_rgb_b;

    vga_if in_if ();
    vga_if out_a ();
    vga_if out_b ();

    draw_tile_grid #(.ROM_LAT(1), .BLINK_FRAMES(2)) dut_a (
        .clk(clk), .rst(rst), .in(in_if), .out(out_a),
        .rom_addr(rom_addr_a), .rom_tile(rom_tile_a), .rom_rgb(rom_rgb_a),
        .sel_tile(sel_tile), .sel_valid(sel_valid), .hl_en(hl_en)
    );

    draw_tile_grid #(.ROM_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .in(in_if), .out(out_b),
        .rom_addr(rom_addr_b), .rom_tile(rom_tile_b), .rom_rgb(rom_rgb_b),
        .sel_tile(sel_tile), .sel_valid(sel_valid), .hl_en(hl_en)
    );

    typedef struct {
        int          due;
        int          id;
        logic [37:0] v;
    } exp_t;

    exp_t qA[$];
    exp_t qB[$];
    exp_t qR[$];
    exp_t eMon;
    int   cyc      = 0;
    int   vecId    = 0;
    int   checks   = 0;
    int   errors   = 0;
    logic flushReq = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Tile ROM models: data is {tile, addr[7:0]}, one or two clocks late.
    always_ff @(posedge clk) begin
        rom_rgb_a <= {1'b0, rom_tile_a, rom_addr_a[7:0]};
        rom_b1    <= {1'b0, rom_tile_b, rom_addr_b[7:0]};
        rom_rgb_b <= rom_b1;
    end

    function automatic logic [37:0] mk(input int hc, input int vc, input int vs,
                                       input int hb, input int vb, input int rgb);
        logic hs;
        hs = 1'(hc) ^ 1'(vc);
        return {11'(hc), 11'(vc), hs, 1'(vs), 1'(hb), 1'(vb), 12'(rgb)};
    endfunction

    function automatic logic [37:0] mkRom(input int addr, input int tile);
        return {20'b0, 15'(addr), 3'(tile)};
    endfunction

    task automatic pushA(input int due, input logic [37:0] v);
        exp_t e;
        e.due = due; e.id = vecId; e.v = v;
        qA.push_back(e);
    endtask

    task automatic pushB(input int due, input logic [37:0] v);
        exp_t e;
        e.due = due; e.id = vecId; e.v = v;
        qB.push_back(e);
    endtask

    task automatic pushR(input int due, input logic [37:0] v);
        exp_t e;
        e.due = due; e.id = vecId; e.v = v;
        qR.push_back(e);
    endtask

    task automatic drivePixel(input int hc, input int vc, input int vs, input int hb,
                              input int vb, input int rgbIn, input int hl);
        @(posedge clk);
        #1;
        in_if.hcount = 11'(hc);
        in_if.vcount = 11'(vc);
        in_if.hsync  = 1'(hc) ^ 1'(vc);
        in_if.vsync  = 1'(vs);
        in_if.hblnk  = 1'(hb);
        in_if.vblnk  = 1'(vb);
        in_if.rgb    = 12'(rgbIn);
        hl_en        = 1'(hl);
        sel_valid    = 1'b0;
    endtask

    task automatic applyStimulus(input int hc, input int vc, input int vs, input int hb,
                                 input int vb, input int rgbIn, input int hl,
                                 input int expRgb, input bit chkB);
        drivePixel(hc, vc, vs, hb, vb, rgbIn, hl);
        vecId++;
        pushA(cyc + 3, mk(hc, vc, vs, hb, vb, expRgb));
        if (chkB) pushB(cyc + 4, mk(hc, vc, vs, hb, vb, expRgb));
    endtask

    task automatic checkRomNext(input int addr, input int tile);
        pushR(cyc + 1, mkRom(addr, tile));
    endtask

    task automatic idle(input int n);
        repeat (n) drivePixel(0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic strobeSel(input int tile, input int vs);
        idle(4);
        drivePixel(0, 0, vs, 1, vs, 0, 0);
        sel_tile  = 3'(tile);
        sel_valid = 1'b1;
    endtask

    task automatic vsyncPulse();
        idle(4);
        applyStimulus(0, 0, 1, 1, 1, 0, 0, 12'h000, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input int id,
                               input logic [37:0] act, input logic [37:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s vec%0d: got %h expected %h", tag, id, act, exp);
        end
    endtask

    task automatic reportTimeout(input string tag, input int id, input int due);
        checks++;
        errors++;
        $display("[TB] FAIL %s vec%0d: no output observed (due cycle %0d, now %0d)",
                 tag, id, due, cyc);
    endtask

    // Monitor pops every expectation whose due cycle has arrived.
    always @(negedge clk) begin
        while (qA.size() > 0 && qA[0].due <= cyc) begin
            eMon = qA.pop_front();
            if (eMon.due < cyc) reportTimeout("outA", eMon.id, eMon.due);
            else checkOutput("outA", eMon.id,
                             {out_a.hcount, out_a.vcount, out_a.hsync, out_a.vsync,
                              out_a.hblnk, out_a.vblnk, out_a.rgb}, eMon.v);
        end
        while (qB.size() > 0 && qB[0].due <= cyc) begin
            eMon = qB.pop_front();
            if (eMon.due < cyc) reportTimeout("outB", eMon.id, eMon.due);
            else checkOutput("outB", eMon.id,
                             {out_b.hcount, out_b.vcount, out_b.hsync, out_b.vsync,
                              out_b.hblnk, out_b.vblnk, out_b.rgb}, eMon.v);
        end
        while (qR.size() > 0 && qR[0].due <= cyc) begin
            eMon = qR.pop_front();
            if (eMon.due < cyc) reportTimeout("rom", eMon.id, eMon.due);
            else checkOutput("rom", eMon.id, {20'b0, rom_addr_a, rom_tile_a}, eMon.v);
        end
        if (flushReq) begin
            while (qA.size() > 0) begin eMon = qA.pop_front(); reportTimeout("outA", eMon.id, eMon.due); end
            while (qB.size() > 0) begin eMon = qB.pop_front(); reportTimeout("outB", eMon.id, eMon.due); end
            while (qR.size() > 0) begin eMon = qR.pop_front(); reportTimeout("rom", eMon.id, eMon.due); end
        end
    end

    initial begin
        rst = 1'b1;
        sel_tile = 3'd0;
        sel_valid = 1'b0;
        hl_en = 1'b0;
        in_if.hcount = '0; in_if.vcount = '0; in_if.hsync = 1'b0; in_if.vsync = 1'b0;
        in_if.hblnk = 1'b0; in_if.vblnk = 1'b0; in_if.rgb = '0;
        repeat (3) @(posedge clk);
        #1;
        pushA(cyc, 38'd0);
        pushB(cyc, 38'd0);
        pushR(cyc, 38'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);

        $display("[TB] geometry, addressing and blanking");
        applyStimulus( 50,  50, 0, 0, 0, 12'h123, 0, 12'h000, 1'b1); checkRomNext(0, 0);
        applyStimulus(455, 275, 0, 0, 0, 12'h456, 0, 12'h511, 1'b1); checkRomNext(785, 5);
        applyStimulus(206,  60, 0, 0, 0, 12'hABC, 0, 12'hABC, 1'b1); checkRomNext(785, 5);
        applyStimulus(249,  60, 0, 0, 0, 12'hABD, 0, 12'hABD, 1'b1);
        applyStimulus(250,  60, 0, 0, 0, 12'hABE, 0, 12'h118, 1'b1); checkRomNext(1560, 1);
        applyStimulus(205, 249, 0, 0, 0, 12'h111, 0, 12'h0DF, 1'b1); checkRomNext(31199, 0);
        applyStimulus(206, 249, 0, 0, 0, 12'h321, 0, 12'h321, 1'b1);
        applyStimulus(100, 250, 0, 0, 0, 12'h654, 0, 12'h654, 1'b1);
        applyStimulus(100, 100, 0, 1, 0, 12'h777, 0, 12'h000, 1'b1);
        applyStimulus(100, 100, 0, 0, 1, 12'h777, 0, 12'h000, 1'b1);
        applyStimulus(100, 249, 0, 0, 0, 12'h777, 0, 12'h076, 1'b1);

        $display("[TB] selection of tile 4");
        strobeSel(4, 0);
        applyStimulus(250, 300, 0, 0, 0, 12'h999, 1, 12'h448, 1'b0);
        vsyncPulse();
        applyStimulus(250, 300, 0, 0, 0, 12'h999, 1, 12'hFF0, 1'b0);
        applyStimulus(403, 300, 0, 0, 0, 12'h999, 1, 12'hFF0, 1'b0);
        applyStimulus(405, 300, 0, 0, 0, 12'h999, 1, 12'hFF0, 1'b0);
        applyStimulus(402, 300, 0, 0, 0, 12'h999, 1, 12'h4E0, 1'b0);
        applyStimulus(253, 300, 0, 0, 0, 12'h999, 1, 12'h44B, 1'b0);
        applyStimulus(260, 300, 0, 0, 0, 12'h999, 1, 12'h452, 1'b0);
        applyStimulus(250, 300, 0, 0, 0, 12'h999, 0, 12'h448, 1'b0);
        applyStimulus( 51,  50, 0, 0, 0, 12'h999, 1, 12'h001, 1'b0);
        applyStimulus(300, 270, 0, 0, 0, 12'h999, 1, 12'hFF0, 1'b0);
        applyStimulus(300, 469, 0, 0, 0, 12'h999, 1, 12'hFF0, 1'b0);
        applyStimulus(300, 466, 0, 0, 0, 12'h999, 1, 12'h4A2, 1'b0);

        $display("[TB] blink phases and same-cycle selection");
        vsyncPulse();
        applyStimulus(250, 300, 0, 0, 0, 12'h999, 1, 12'h448, 1'b0);
        vsyncPulse();
        applyStimulus(250, 300, 0, 0, 0, 12'h999, 1, 12'h448, 1'b0);
        strobeSel(0, 1);
        applyStimulus( 50,  50, 0, 0, 0, 12'h999, 0, 12'h000, 1'b0);
        applyStimulus( 51,  50, 0, 0, 0, 12'h999, 1, 12'hFF0, 1'b0);
        applyStimulus(250, 300, 0, 0, 0, 12'h999, 1, 12'h448, 1'b0);

        $display("[TB] out-of-range selection");
        strobeSel(6, 0);
        vsyncPulse();
        applyStimulus( 50,  50, 0, 0, 0, 12'h999, 1, 12'h000, 1'b0);
        applyStimulus(250, 300, 0, 0, 0, 12'h999, 1, 12'h448, 1'b0);

        $display("[TB] reset during active video");
        strobeSel(5, 0);
        repeat (3) drivePixel(455, 275, 0, 0, 0, 12'h777, 1);
        drivePixel(455, 275, 0, 0, 0, 12'h777, 1);
        rst = 1'b1;
        vecId++;
        pushA(cyc + 1, 38'd0);
        pushR(cyc + 1, 38'd0);
        drivePixel(455, 275, 0, 0, 0, 12'h777, 1);
        pushA(cyc + 1, 38'd0);
        drivePixel(450, 275, 0, 0, 0, 12'h777, 1);
        rst = 1'b0;
        pushA(cyc + 1, 38'd0);
        pushA(cyc + 2, 38'd0);
        pushA(cyc + 3, mk(450, 275, 0, 0, 0, 12'h50C));
        checkRomNext(780, 5);
        vsyncPulse();
        applyStimulus(450, 275, 0, 0, 0, 12'h777, 1, 12'h50C, 1'b0);
        idle(2);

        for (int i = 0; i < 40 && (qA.size() + qB.size() + qR.size()) > 0; i++)
            @(negedge clk);
        flushReq = 1'b1;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
